sn_stream_decoder: RTL and testbench
====================================

# sn_stream_decoder

Output-side decoder for a fully connected stochastic layer. It counts the ones on each of N parallel stochastic output streams (the layer's `a_out` bus) over a fixed window of 2^WIN_LOG2 sampled cycles. It then publishes the per-node counts as binary values and, optionally, the index of the most active node. It sits directly downstream of the layer block and hands binary results to the host/training controller through a START/BUSY/DONE handshake.

## Interface
Parameters:
- `N`, 25: number of stream channels (layer width).
- `WIN_LOG2`, 8: log2 of the counting window length. Each count is CW = WIN_LOG2+1 bits wide.
- `SETTLE`, 4: cycles discarded after START to let node state memories fill. 0 is legal and skips the SETTLE state.
- `IDXW`, 5: width of the argmax index. Requires 2^IDXW ≥ N.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `INIT_N`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `START`, in, 1: level sampled on the clock edge; it is acted on only in IDLE.
- `ABORT`, in, 1: synchronous; returns the block to IDLE from any state.
- `HOLD`, in, 1: freezes SETTLE/COUNT progress and counting while high.
- `STREAM_IN`, in, N: stochastic bits, one per node.
- `BUSY`, out, 1: high in every state except IDLE.
- `DONE`, out, 1: one-cycle pulse when results are updated.
- `COUNT_OUT`, out, N*CW: channel i is at bits [i*CW +: CW]; registered and held between DONE pulses.
- `MAX_IDX`, out, IDXW: index of the largest count.
- `MAX_VAL`, out, CW: value of the largest count.

## Operation
- Reset (`INIT_N`=0): state goes to IDLE and every output register, counter and output goes to 0.
- IDLE:
  - `START`=1 and `ABORT`=0 → SETTLE, or → COUNT if SETTLE=0.
  - On entry to COUNT, the cycle counter and all working counters are cleared.
- SETTLE: counts SETTLE un-held cycles, then → COUNT. `STREAM_IN` is ignored.
- COUNT:
  - Each un-held cycle, working counter i increments when `STREAM_IN[i]`=1.
  - After exactly 2^WIN_LOG2 un-held cycles → SCAN (macro on) or FINISH (macro off).
  - Counters never wrap; the maximum value is 2^WIN_LOG2.
- SCAN:
  - Sequential compare, one channel per cycle, index 0..N-1, taking N cycles. `HOLD` does not affect SCAN.
  - A candidate replaces the running max only if it is strictly greater, so ties resolve to the lowest index. An all-zero result gives index 0.
- FINISH (one cycle):
  - Copies the working counters to `COUNT_OUT` and the scan result to `MAX_IDX`/`MAX_VAL`.
  - Asserts `DONE` for this cycle, then → IDLE.
- `ABORT` in any state → IDLE next edge. Outputs keep their previous values and `DONE` is not pulsed. `ABORT` has priority over `START`, `HOLD` and normal transitions.
- `START` outside IDLE is ignored, including in FINISH; it is not queued.

## Timing
- Let START be sampled at edge t0 with no HOLD. With the macro on, `DONE` is high in the cycle beginning at edge t0 + SETTLE + 2^WIN_LOG2 + N + 1.
  - With the macro off, the offset is t0 + SETTLE + 2^WIN_LOG2 + 1.
- Each HOLD cycle during SETTLE/COUNT adds exactly one cycle of latency.
- `BUSY` rises at edge t0+1. It falls on the edge after the `DONE` cycle, or on the edge after an `ABORT` is sampled.
- `COUNT_OUT`, `MAX_IDX` and `MAX_VAL` change only on the same edge that raises `DONE`.
- Sampling: `STREAM_IN` bits are counted on the clock edge that ends each un-held COUNT cycle.
- Asynchronous reset mid-operation: all state clears immediately. After `INIT_N` is released, a new `START` is required.

## Configuration
- `SN_DECODER_ARGMAX_EN` defined: the SCAN state and compare logic are compiled in, and `MAX_IDX`/`MAX_VAL` are live.
- Undefined: no SCAN state; COUNT goes directly to FINISH. `MAX_IDX` and `MAX_VAL` are tied to 0 and latency drops by N cycles.

## Test plan
All scenarios use N=4, WIN_LOG2=4, SETTLE=2 and the macro on unless stated.
- All-ones: `STREAM_IN`=4'b1111 throughout, START pulsed at t0.
  - `DONE` at t0+23.
  - Every count equals 16, `MAX_IDX`=0, `MAX_VAL`=16.
- Pattern: channel 2 held at 1 and channel 1 alternating 1/0; the other channels 0.
  - Counts {0,8,16,0}; `MAX_IDX`=2, `MAX_VAL`=16.
- HOLD: `HOLD` high for 5 cycles mid-COUNT, with `STREAM_IN`=1 on those cycles.
  - Counts are still 16 and `DONE` moves to t0+28.
- Tie: channels 1 and 3 both constant 1.
  - `MAX_IDX`=1.
- ABORT mid-COUNT after a completed run.
  - `BUSY` falls the next cycle with no `DONE`, and `COUNT_OUT` keeps the prior results.
  - START during BUSY is ignored.
- Reset and macro-off build:
  - `INIT_N` low mid-SCAN clears all outputs to 0 immediately.
  - With the macro undefined, `DONE` arrives at t0+19 and `MAX_IDX`=0.

Source files
------------

// File: rtl/sn_stream_decoder.sv
// Windowed ones-counter for N stochastic streams with a START/BUSY/DONE handshake.
// Define SN_DECODER_ARGMAX_EN to compile in the sequential argmax scan (MAX_IDX/MAX_VAL).
module sn_stream_decoder #(
   parameter int N        = 25,
   parameter int WIN_LOG2 = 8,
   parameter int SETTLE   = 4,
   parameter int IDXW     = 5
) (
   input  logic                      CLK,
   input  logic                      INIT_N,
   input  logic                      START,
   input  logic                      ABORT,
   input  logic                      HOLD,
   input  logic [N-1:0]              STREAM_IN,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [N*(WIN_LOG2+1)-1:0] COUNT_OUT,
   output logic [IDXW-1:0]           MAX_IDX,
   output logic [WIN_LOG2:0]         MAX_VAL
);
   localparam int CW = WIN_LOG2 + 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX = CW'(1 << WIN_LOG2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COUNT,
`ifdef SN_DECODER_ARGMAX_EN
      ST_SCAN,
`endif
      ST_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic                start_q, start_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [CW-1:0]       cnt_q [N];
   logic [CW-1:0]       cnt_d [N];
   logic                done_q, done_d;
   logic [N*CW-1:0]     count_out_q, count_out_d;
   logic                load;

`ifdef SN_DECODER_ARGMAX_EN
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   logic [IDXW-1:0] scan_idx_q, scan_idx_d;
   logic [CW-1:0]   run_max_q, run_max_d;
   logic [IDXW-1:0] run_idx_q, run_idx_d;
   logic [IDXW-1:0] max_idx_q, max_idx_d;
   logic [CW-1:0]   max_val_q, max_val_d;
   logic [CW-1:0]   cand;
`endif

   always_ff @(posedge CLK or negedge INIT_N) begin
      if (!INIT_N) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         settle_q    <= '0;
         win_q       <= '0;
         cnt_q       <= '{default: '0};
         done_q      <= 1'b0;
         count_out_q <= '0;
`ifdef SN_DECODER_ARGMAX_EN
         scan_idx_q  <= '0;
         run_max_q   <= '0;
         run_idx_q   <= '0;
         max_idx_q   <= '0;
         max_val_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         settle_q    <= settle_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         count_out_q <= count_out_d;
`ifdef SN_DECODER_ARGMAX_EN
         scan_idx_q  <= scan_idx_d;
         run_max_q   <= run_max_d;
         run_idx_q   <= run_idx_d;
         max_idx_q   <= max_idx_d;
         max_val_q   <= max_val_d;
`endif
      end
   end

   // START is only captured while idle, so a request made while busy is never queued.
   always_comb begin
      state_d     = state_q;
      start_d     = START & ~ABORT & (state_q == ST_IDLE);
      settle_d    = settle_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      count_out_d = count_out_q;
      load        = 1'b0;
`ifdef SN_DECODER_ARGMAX_EN
      scan_idx_d  = scan_idx_q;
      run_max_d   = run_max_q;
      run_idx_d   = run_idx_q;
      max_idx_d   = max_idx_q;
      max_val_d   = max_val_q;
      cand        = '0;
      for (int i = 0; i < N; i++) begin
         if (scan_idx_q == IDXW'(i)) cand = cnt_q[i];
      end
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               if (SETTLE == 0) begin
                  state_d = ST_COUNT;
                  win_d   = '0;
                  cnt_d   = '{default: '0};
               end else begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end
            end
         end
         ST_SETTLE: begin
            if (!HOLD) begin
               if (settle_q == SETTLE_LAST) begin
                  state_d = ST_COUNT;
                  win_d   = '0;
                  cnt_d   = '{default: '0};
               end else begin
                  settle_d = settle_q + SW'(1);
               end
            end
         end
         ST_COUNT: begin
            if (!HOLD) begin
               for (int i = 0; i < N; i++) begin
                  if (STREAM_IN[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CW'(1);
               end
               if (win_q == '1) begin
`ifdef SN_DECODER_ARGMAX_EN
                  state_d    = ST_SCAN;
                  scan_idx_d = '0;
                  run_max_d  = '0;
                  run_idx_d  = '0;
`else
                  state_d = ST_FINISH;
                  load    = 1'b1;
`endif
               end else begin
                  win_d = win_q + WIN_LOG2'(1);
               end
            end
         end
`ifdef SN_DECODER_ARGMAX_EN
         // Strictly-greater replacement keeps the lowest index on ties.
         ST_SCAN: begin
            if (cand > run_max_q) begin
               run_max_d = cand;
               run_idx_d = scan_idx_q;
            end
            if (scan_idx_q == LAST_IDX) begin
               state_d = ST_FINISH;
               load    = 1'b1;
            end else begin
               scan_idx_d = scan_idx_q + IDXW'(1);
            end
         end
`endif
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (ABORT) begin
         state_d = ST_IDLE;
         load    = 1'b0;
      end

      // Results publish on the edge entering FINISH, together with the DONE pulse.
      done_d = load;
      if (load) begin
         for (int i = 0; i < N; i++) count_out_d[i*CW +: CW] = cnt_d[i];
`ifdef SN_DECODER_ARGMAX_EN
         max_idx_d = run_idx_d;
         max_val_d = run_max_d;
`endif
      end
   end

   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = done_q;
   assign COUNT_OUT = count_out_q;
`ifdef SN_DECODER_ARGMAX_EN
   assign MAX_IDX   = max_idx_q;
   assign MAX_VAL   = max_val_q;
`else
   assign MAX_IDX   = '0;
   assign MAX_VAL   = '0;
`endif

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Self-checking bench for sn_stream_decoder: directed vector table, handshake corner cases,
// and randomized windows checked against a cycle-walk reference model.
module tb_sn_stream_decoder;
   localparam int N        = 4;
   localparam int WIN_LOG2 = 4;
   localparam int SETTLE   = 2;
   localparam int IDXW     = 2;
   localparam int CW       = WIN_LOG2 + 1;
   localparam int WIN      = 1 << WIN_LOG2;
   localparam int LIMIT    = 200;
`ifdef SN_DECODER_ARGMAX_EN
   localparam int SCAN_LAT  = N;
   localparam bit ARGMAX_ON = 1'b1;
`else
   localparam int SCAN_LAT  = 0;
   localparam bit ARGMAX_ON = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            INIT_N;
   logic            START;
   logic            ABORT;
   logic            HOLD;
   logic [N-1:0]    STREAM_IN;
   logic            BUSY;
   logic            DONE;
   logic [N*CW-1:0] COUNT_OUT;
   logic [IDXW-1:0] MAX_IDX;
   logic [CW-1:0]   MAX_VAL;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      string           name;
      logic [N-1:0]    constBits;
      bit              altCh1;
      int              holdFrom;
      int              holdLen;
      logic [N*CW-1:0] expCounts;
      int              expIdx;
      int              expVal;
      int              expLatency;
   } vec_t;

   vec_t vecs [4];

   sn_stream_decoder #(
      .N(N), .WIN_LOG2(WIN_LOG2), .SETTLE(SETTLE), .IDXW(IDXW)
   ) dut (
      .CLK(CLK), .INIT_N(INIT_N), .START(START), .ABORT(ABORT), .HOLD(HOLD),
      .STREAM_IN(STREAM_IN), .BUSY(BUSY), .DONE(DONE), .COUNT_OUT(COUNT_OUT),
      .MAX_IDX(MAX_IDX), .MAX_VAL(MAX_VAL)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Lowest index holding the largest count.
   function automatic void refArgmax(input logic [N*CW-1:0] c, output int idx, output int val);
      val = 0;
      idx = 0;
      for (int i = 0; i < N; i++) if (int'(c[i*CW +: CW]) > val) val = int'(c[i*CW +: CW]);
      for (int i = N - 1; i >= 0; i--) if (int'(c[i*CW +: CW]) == val) idx = i;
   endfunction

   // Drives one START-to-DONE window. Edge 0 samples START; from edge 2 on, the first SETTLE
   // un-held edges are settle time and the next WIN un-held edges are counted.
   task automatic applyStimulus(input logic [N-1:0] constBits, input bit altCh1,
                                input int holdFrom, input int holdLen,
                                input bit randomMode, input int holdPct, input int restartAt,
                                output int doneEdge, output logic [N*CW-1:0] modelCounts,
                                output int modelDone);
      int settleLeft = SETTLE;
      int countLeft  = WIN;
      int cnt [N];
      logic [N-1:0] bits;
      bit h;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      doneEdge  = -1;
      modelDone = -1;
      @(negedge CLK);
      START = 1'b1; ABORT = 1'b0; HOLD = 1'b0; STREAM_IN = constBits;
      for (int e = 1; e <= LIMIT; e++) begin
         @(negedge CLK);
         if (e == 1) checkOutput("busy_before_rise", BUSY, 0);
         if (e == 2) checkOutput("busy_rise", BUSY, 1);
         if (DONE) begin
            doneEdge = e - 1;
            break;
         end
         START = (e == restartAt);
         if (randomMode) begin
            bits = N'($urandom);
            h    = ($urandom_range(99) < holdPct);
         end else begin
            bits = constBits | ((altCh1 && (e % 2 == 0)) ? N'(2) : N'(0));
            h    = (e >= holdFrom) && (e < holdFrom + holdLen);
         end
         STREAM_IN = bits;
         HOLD      = h;
         if (e >= 2 && !h) begin
            if (settleLeft > 0) settleLeft--;
            else if (countLeft > 0) begin
               for (int i = 0; i < N; i++) cnt[i] += int'(bits[i]);
               countLeft--;
               if (countLeft == 0) modelDone = e + SCAN_LAT;
            end
         end
      end
      START = 1'b0;
      HOLD  = 1'b0;
      if (doneEdge < 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL done_timeout: no DONE within %0d cycles", LIMIT);
      end
      for (int i = 0; i < N; i++) modelCounts[i*CW +: CW] = CW'(cnt[i]);
   endtask

   int              doneEdge;
   int              mDone;
   logic [N*CW-1:0] mCounts;
   int              rIdx;
   int              rVal;
   bit              sawDone;
   bit              sawBusy;

   initial begin
      vecs[0] = '{"all_ones", 4'b1111, 1'b0, 0, 0, {5'd16, 5'd16, 5'd16, 5'd16}, 0, 16, 23};
      vecs[1] = '{"pattern",  4'b0100, 1'b1, 0, 0, {5'd0, 5'd16, 5'd8, 5'd0},    2, 16, 23};
      vecs[2] = '{"hold",     4'b1111, 1'b0, 8, 5, {5'd16, 5'd16, 5'd16, 5'd16}, 0, 16, 28};
      vecs[3] = '{"tie",      4'b1010, 1'b0, 0, 0, {5'd16, 5'd0, 5'd16, 5'd0},   1, 16, 23};

      INIT_N = 1'b0; START = 1'b0; ABORT = 1'b0; HOLD = 1'b0; STREAM_IN = '0;
      repeat (3) @(negedge CLK);
      checkOutput("reset_busy", BUSY, 0);
      checkOutput("reset_done", DONE, 0);
      checkOutput("reset_counts", COUNT_OUT, 0);
      checkOutput("reset_max_idx", MAX_IDX, 0);
      checkOutput("reset_max_val", MAX_VAL, 0);
      INIT_N = 1'b1;

      // Directed table; every run also pulses START mid-run and in the DONE cycle.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(vecs[k].constBits, vecs[k].altCh1, vecs[k].holdFrom, vecs[k].holdLen,
                       1'b0, 0, 10, doneEdge, mCounts, mDone);
         checkOutput({vecs[k].name, "_latency"}, doneEdge, vecs[k].expLatency - N + SCAN_LAT);
         checkOutput({vecs[k].name, "_counts"}, COUNT_OUT, vecs[k].expCounts);
         checkOutput({vecs[k].name, "_max_idx"}, MAX_IDX, ARGMAX_ON ? vecs[k].expIdx : 0);
         checkOutput({vecs[k].name, "_max_val"}, MAX_VAL, ARGMAX_ON ? vecs[k].expVal : 0);
         checkOutput({vecs[k].name, "_busy_in_done"}, BUSY, 1);
         START = 1'b1;
         @(negedge CLK);
         START = 1'b0;
         checkOutput({vecs[k].name, "_busy_fall"}, BUSY, 0);
         checkOutput({vecs[k].name, "_done_pulse"}, DONE, 0);
         @(negedge CLK);
         checkOutput({vecs[k].name, "_start_not_queued"}, BUSY, 0);
      end

      // ABORT mid-COUNT keeps the previous results and never pulses DONE.
      @(negedge CLK);
      START = 1'b1; STREAM_IN = '1;
      @(negedge CLK);
      START = 1'b0;
      repeat (8) @(negedge CLK);
      checkOutput("abort_busy_before", BUSY, 1);
      ABORT = 1'b1; START = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0; START = 1'b0;
      checkOutput("abort_busy_fall", BUSY, 0);
      checkOutput("abort_no_done", DONE, 0);
      checkOutput("abort_keeps_counts", COUNT_OUT, vecs[3].expCounts);
      checkOutput("abort_keeps_idx", MAX_IDX, ARGMAX_ON ? vecs[3].expIdx : 0);
      sawDone = 1'b0; sawBusy = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         sawDone |= DONE;
         sawBusy |= BUSY;
      end
      checkOutput("abort_no_late_done", sawDone, 0);
      checkOutput("abort_stays_idle", sawBusy, 0);

      // ABORT wins over START in IDLE.
      START = 1'b1; ABORT = 1'b1;
      @(negedge CLK);
      START = 1'b0; ABORT = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("abort_beats_start", BUSY, 0);

      // Asynchronous reset mid-SCAN (mid-COUNT when the scan is not built).
      START = 1'b1; STREAM_IN = '1;
      @(negedge CLK);
      START = 1'b0;
      repeat (ARGMAX_ON ? 20 : 15) @(negedge CLK);
      checkOutput("prereset_busy", BUSY, 1);
      INIT_N = 1'b0;
      #1;
      checkOutput("async_reset_busy", BUSY, 0);
      checkOutput("async_reset_done", DONE, 0);
      checkOutput("async_reset_counts", COUNT_OUT, 0);
      checkOutput("async_reset_max_idx", MAX_IDX, 0);
      checkOutput("async_reset_max_val", MAX_VAL, 0);
      @(negedge CLK);
      INIT_N = 1'b1;
      sawBusy = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         sawBusy |= BUSY;
      end
      checkOutput("reset_needs_new_start", sawBusy, 0);

      // Randomized windows against the reference model.
      for (int r = 0; r < 8; r++) begin
         applyStimulus('0, 1'b0, 0, 0, 1'b1, 20, (r % 2 == 0) ? 9 : 0, doneEdge, mCounts, mDone);
         refArgmax(mCounts, rIdx, rVal);
         checkOutput("rand_latency", doneEdge, mDone);
         checkOutput("rand_counts", COUNT_OUT, mCounts);
         checkOutput("rand_max_idx", MAX_IDX, ARGMAX_ON ? rIdx : 0);
         checkOutput("rand_max_val", MAX_VAL, ARGMAX_ON ? rVal : 0);
         @(negedge CLK);
         checkOutput("rand_busy_fall", BUSY, 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
